// File: rtl/qsn_shift_sched_len15.sv
// Round-robin scheduler for the shared length-15 QSN. It grants one requester per cycle and
// turns each cyclic shift into left/right select words and a merge mask. The mask, source
// and tag are carried alongside the QSN pipeline so they leave aligned with the merged data.
module qsn_shift_sched_len15 #(
    parameter int QSN_SIZE = 15,
    parameter int SHIFT_W  = 4,
    parameter int TAG_W    = 3,
    parameter int QSN_LAT  = 1
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                req_a_valid,
    input  logic                req_b_valid,
    output logic                req_a_ready,
    output logic                req_b_ready,
    input  logic [SHIFT_W-1:0]  req_a_shift,
    input  logic [SHIFT_W-1:0]  req_b_shift,
    input  logic [TAG_W-1:0]    req_a_tag,
    input  logic [TAG_W-1:0]    req_b_tag,
    input  logic                req_a_last,
    input  logic                req_b_last,
    input  logic                flush,
    output logic                qsn_in_valid,
    output logic                qsn_in_src,
    output logic [SHIFT_W-1:0]  qsn_sel_left,
    output logic [SHIFT_W-1:0]  qsn_sel_right,
    output logic [QSN_SIZE-1:0] qsn_merge_mask,
    output logic                out_valid,
    output logic                out_src,
    output logic [TAG_W-1:0]    out_tag,
    output logic                err_shift,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    typedef struct packed {
        logic                valid;
        logic                src;
        logic [TAG_W-1:0]    tag;
        logic [QSN_SIZE-1:0] mask;
    } beat_t;

    localparam logic [SHIFT_W-1:0] Z = SHIFT_W'(QSN_SIZE);

    state_t              state_q, state_d;
    logic                last_owner_q;          // 0 = A, 1 = B
    beat_t               in_beat_q;
    beat_t               pipe_q [QSN_LAT];

    logic                acc_a, acc_b, acc;
    logic [SHIFT_W-1:0]  acc_shift, s_eff, sel_right_d;
    logic [TAG_W-1:0]    acc_tag;
    logic                acc_last, shift_bad;
    logic [QSN_SIZE-1:0] mask_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        req_a_ready = 1'b0;
        req_b_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req_a_valid && req_b_valid) begin
                        req_a_ready = last_owner_q;
                        req_b_ready = !last_owner_q;
                    end else begin
                        req_a_ready = req_a_valid;
                        req_b_ready = req_b_valid;
                    end
                end
                OWN_A:   req_a_ready = req_a_valid;
                OWN_B:   req_b_ready = req_b_valid;
                default: ;
            endcase
        end
    end

    assign acc_a     = req_a_valid && req_a_ready;
    assign acc_b     = req_b_valid && req_b_ready;
    assign acc       = acc_a || acc_b;
    assign acc_shift = acc_b ? req_b_shift : req_a_shift;
    assign acc_tag   = acc_b ? req_b_tag   : req_a_tag;
    assign acc_last  = acc_b ? req_b_last  : req_a_last;

    // Out-of-range shifts degrade to the identity rotation.
    assign shift_bad   = (acc_shift >= Z);
    assign s_eff       = shift_bad ? '0 : acc_shift;
    assign sel_right_d = (s_eff == '0) ? '0 : Z - s_eff;

    always_comb begin
        mask_d = '0;
        for (int i = 0; i < QSN_SIZE; i++) begin
            mask_d[i] = (i < (QSN_SIZE - int'(s_eff))) && (i < (QSN_SIZE - 1));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc && !acc_last) state_d = acc_b ? OWN_B : OWN_A;
            end
            OWN_A, OWN_B: begin
                if (acc && acc_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_owner_q  <= 1'b0;
            in_beat_q     <= '0;
            qsn_sel_left  <= '0;
            qsn_sel_right <= '0;
            err_shift     <= 1'b0;
            // NOTE: the side pipeline is a handful of flops, so its payload is cleared too and every output reads 0 after reset.
            for (int k = 0; k < QSN_LAT; k++) pipe_q[k] <= '0;
        end else begin
            state_q         <= state_d;
            in_beat_q.valid <= acc;
            err_shift       <= acc && shift_bad;
            if (acc) begin
                last_owner_q   <= acc_b;
                in_beat_q.src  <= acc_b;
                in_beat_q.tag  <= acc_tag;
                in_beat_q.mask <= mask_d;
                qsn_sel_left   <= s_eff;
                qsn_sel_right  <= sel_right_d;
            end
            pipe_q[0] <= in_beat_q;
            for (int k = 1; k < QSN_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign qsn_in_valid   = in_beat_q.valid;
    assign qsn_in_src     = in_beat_q.src;
    assign out_valid      = pipe_q[QSN_LAT-1].valid;
    assign out_src        = pipe_q[QSN_LAT-1].src;
    assign out_tag        = pipe_q[QSN_LAT-1].tag;
    assign qsn_merge_mask = pipe_q[QSN_LAT-1].mask;

    always_comb begin
        busy = (state_q != IDLE) || in_beat_q.valid;
        for (int k = 0; k < QSN_LAT; k++) busy = busy || pipe_q[k].valid;
    end

endmodule

// File: tb/tb_qsn_shift_sched_len15.sv
// Bench for qsn_shift_sched_len15: a beat-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_qsn_shift_sched_len15;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a_valid = 1'b0, req_b_valid = 1'b0;
    logic        req_a_ready, req_b_ready;
    logic [3:0]  req_a_shift = '0, req_b_shift = '0;
    logic [2:0]  req_a_tag = '0, req_b_tag = '0;
    logic        req_a_last = 1'b0, req_b_last = 1'b0;
    logic        flush = 1'b0;
    logic        qsn_in_valid, qsn_in_src;
    logic [3:0]  qsn_sel_left, qsn_sel_right;
    logic [14:0] qsn_merge_mask;
    logic        out_valid, out_src;
    logic [2:0]  out_tag;
    logic        err_shift, busy;

    int checks = 0;
    int errors = 0;

    qsn_shift_sched_len15 dut (
        .sys_clk(sys_clk), .rst(rst),
        .req_a_valid(req_a_valid), .req_b_valid(req_b_valid),
        .req_a_ready(req_a_ready), .req_b_ready(req_b_ready),
        .req_a_shift(req_a_shift), .req_b_shift(req_b_shift),
        .req_a_tag(req_a_tag), .req_b_tag(req_b_tag),
        .req_a_last(req_a_last), .req_b_last(req_b_last),
        .flush(flush),
        .qsn_in_valid(qsn_in_valid), .qsn_in_src(qsn_in_src),
        .qsn_sel_left(qsn_sel_left), .qsn_sel_right(qsn_sel_right),
        .qsn_merge_mask(qsn_merge_mask),
        .out_valid(out_valid), .out_src(out_src), .out_tag(out_tag),
        .err_shift(err_shift), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- beat-level model ----------------
    int          m_owner = 0;   // 0 none, 1 A, 2 B
    bit          m_last = 1'b0; // last granted: 0 A, 1 B
    bit          m_ok = 1'b0;
    logic        m_in_valid, m_in_src, m_err;
    logic [3:0]  m_sl, m_sr;
    logic [2:0]  m_in_tag, m_out_tag;
    logic [14:0] m_in_mask, m_out_mask;
    logic        m_out_valid, m_out_src;

    function automatic logic [1:0] exp_ready();   // {b, a}
        if (rst) return 2'b00;
        if (m_owner == 1) return {1'b0, req_a_valid};
        if (m_owner == 2) return {req_b_valid, 1'b0};
        if (req_a_valid && req_b_valid) return m_last ? 2'b01 : 2'b10;
        return {req_b_valid, req_a_valid};
    endfunction

    always @(posedge sys_clk) begin
        logic [1:0] r;
        logic ga, gb, lst;
        int s, mk;
        if (rst) begin
            m_owner = 0; m_last = 1'b0; m_ok = 1'b1;
            m_in_valid = 0; m_in_src = 0; m_err = 0; m_sl = 0; m_sr = 0;
            m_in_tag = 0; m_in_mask = 0;
            m_out_valid = 0; m_out_src = 0; m_out_tag = 0; m_out_mask = 0;
        end else begin
            r  = exp_ready();
            ga = req_a_valid && r[0];
            gb = req_b_valid && r[1];
            m_out_valid = m_in_valid; m_out_src = m_in_src;
            m_out_tag = m_in_tag;     m_out_mask = m_in_mask;
            m_in_valid = ga || gb;
            m_err = 1'b0;
            if (ga || gb) begin
                s   = gb ? int'(req_b_shift) : int'(req_a_shift);
                lst = gb ? req_b_last : req_a_last;
                if (s >= 15) begin m_err = 1'b1; s = 0; end
                m_sl = 4'(s);
                m_sr = (s == 0) ? 4'd0 : 4'(15 - s);
                mk = ((1 << (15 - s)) - 1) & 'h3FFF;
                m_in_mask = 15'(mk);
                m_in_src  = gb;
                m_in_tag  = gb ? req_b_tag : req_a_tag;
                if (m_owner == 0) begin
                    if (!lst) m_owner = gb ? 2 : 1;
                end else if (lst) begin
                    m_owner = 0;
                end
                m_last = gb;
            end
            if (flush) m_owner = 0;
        end
    end

    always @(negedge sys_clk) begin
        logic [1:0] r;
        if (m_ok) begin
            r = exp_ready();
            check("m_ready_a", 32'(req_a_ready), 32'(r[0]));
            check("m_ready_b", 32'(req_b_ready), 32'(r[1]));
            check("m_in_valid", 32'(qsn_in_valid), 32'(m_in_valid));
            check("m_sel_left", 32'(qsn_sel_left), 32'(m_sl));
            check("m_sel_right", 32'(qsn_sel_right), 32'(m_sr));
            check("m_err_shift", 32'(err_shift), 32'(m_err));
            check("m_busy", 32'(busy), 32'((m_owner != 0) || m_in_valid || m_out_valid));
            check("m_out_valid", 32'(out_valid), 32'(m_out_valid));
            if (m_in_valid) check("m_in_src", 32'(qsn_in_src), 32'(m_in_src));
            if (m_out_valid) begin
                check("m_out_src", 32'(out_src), 32'(m_out_src));
                check("m_out_tag", 32'(out_tag), 32'(m_out_tag));
                check("m_out_mask", 32'(qsn_merge_mask), 32'(m_out_mask));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic set_a(input logic v, input logic [3:0] s, input logic [2:0] t, input logic l);
        req_a_valid = v; req_a_shift = s; req_a_tag = t; req_a_last = l;
    endtask

    task automatic set_b(input logic v, input logic [3:0] s, input logic [2:0] t, input logic l);
        req_b_valid = v; req_b_shift = s; req_b_tag = t; req_b_last = l;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_in_valid", 32'(qsn_in_valid), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sel_left", 32'(qsn_sel_left), 0);
        check("rst_sel_right", 32'(qsn_sel_right), 0);
        check("rst_mask", 32'(qsn_merge_mask), 0);
        check("rst_err", 32'(err_shift), 0);
        check("rst_out_tag", 32'(out_tag), 0);

        // A alone, shift 5, tag 3
        set_a(1, 4'd5, 3'd3, 1);
        #1 check("a5_ready", 32'(req_a_ready), 1);
        tick(); req_a_valid = 0;
        #1;
        check("a5_sel_left", 32'(qsn_sel_left), 5);
        check("a5_sel_right", 32'(qsn_sel_right), 10);
        check("a5_src", 32'(qsn_in_src), 0);
        check("a5_in_valid", 32'(qsn_in_valid), 1);
        tick(); #1;
        check("a5_out_valid", 32'(out_valid), 1);
        check("a5_out_tag", 32'(out_tag), 3);
        check("a5_mask", 32'(qsn_merge_mask), 'h03FF);

        // Shift 0, then shift 15 (error, treated as 0)
        set_a(1, 4'd0, 3'd1, 1);
        tick(); #1;
        check("s0_sel_left", 32'(qsn_sel_left), 0);
        check("s0_sel_right", 32'(qsn_sel_right), 0);
        check("s0_err", 32'(err_shift), 0);
        set_a(1, 4'd15, 3'd2, 1);
        tick(); req_a_valid = 0; #1;
        check("s15_err", 32'(err_shift), 1);
        check("s15_sel_left", 32'(qsn_sel_left), 0);
        check("s15_sel_right", 32'(qsn_sel_right), 0);
        check("s0_mask", 32'(qsn_merge_mask), 'h3FFF);
        tick(); #1;
        check("s15_err_pulse", 32'(err_shift), 0);
        check("s15_mask", 32'(qsn_merge_mask), 'h3FFF);
        check("s15_tag", 32'(out_tag), 2);

        // Select words hold while idle
        set_a(1, 4'd7, 3'd4, 1);
        tick(); req_a_valid = 0;
        tick(); #1;
        check("hold_in_valid", 32'(qsn_in_valid), 0);
        check("hold_sel_left", 32'(qsn_sel_left), 7);
        check("hold_sel_right", 32'(qsn_sel_right), 8);
        tick();

        // Round robin from reset: B, A, B, A
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_a(1, 4'd1, 3'd5, 1);
        set_b(1, 4'd2, 3'd6, 1);
        #1 check("rr1_b", 32'({req_b_ready, req_a_ready}), 2);
        tick(); #1 check("rr2_a", 32'({req_b_ready, req_a_ready}), 1);
        tick(); #1 check("rr3_b", 32'({req_b_ready, req_a_ready}), 2);
        check("rr_out_src1", 32'(out_src), 1);
        tick(); #1 check("rr4_a", 32'({req_b_ready, req_a_ready}), 1);
        check("rr_out_src0", 32'(out_src), 0);
        tick();
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        tick(); tick();

        // A 4-beat burst blocks B
        set_a(1, 4'd3, 3'd1, 0);
        tick();
        set_b(1, 4'd4, 3'd7, 1);
        #1 check("burst_b_blocked1", 32'({req_b_ready, req_a_ready}), 1);
        tick(); tick();
        req_a_last = 1;
        #1 check("burst_b_blocked4", 32'(req_b_ready), 0);
        tick(); req_a_valid = 0;
        #1 check("burst_b_granted", 32'(req_b_ready), 1);
        tick(); req_b_valid = 0;
        tick(); tick();

        // Owner bubbles keep ownership
        set_a(1, 4'd6, 3'd2, 0);
        tick(); req_a_valid = 0;
        set_b(1, 4'd1, 3'd1, 1);
        #1 check("bub_b_blocked", 32'(req_b_ready), 0);
        tick(); #1;
        check("bub1_in_valid", 32'(qsn_in_valid), 0);
        check("bub1_busy", 32'(busy), 1);
        tick(); #1;
        check("bub2_in_valid", 32'(qsn_in_valid), 0);
        check("bub2_b_blocked", 32'(req_b_ready), 0);
        set_a(1, 4'd6, 3'd3, 1);
        tick(); req_a_valid = 0;
        #1 check("bub_b_after", 32'(req_b_ready), 1);
        tick(); req_b_valid = 0;
        tick(); tick();

        // Flush mid A-burst
        set_a(1, 4'd9, 3'd4, 0);
        tick();
        set_a(1, 4'd10, 3'd5, 0);
        set_b(1, 4'd2, 3'd6, 1);
        flush = 1;
        #1 check("fl_a_ready", 32'({req_b_ready, req_a_ready}), 1);
        tick(); flush = 0;
        #1;
        check("fl_b_granted", 32'({req_b_ready, req_a_ready}), 2);
        check("fl_in_valid", 32'(qsn_in_valid), 1);
        tick(); req_a_valid = 0; req_b_valid = 0;
        #1;
        check("fl_out_valid", 32'(out_valid), 1);
        check("fl_out_src", 32'(out_src), 0);
        check("fl_out_tag", 32'(out_tag), 5);
        tick(); tick(); tick();

        // Reset mid-burst
        set_a(1, 4'd3, 3'd2, 0);
        tick();
        set_a(1, 4'd4, 3'd3, 0);
        tick();
        rst = 1'b1;
        tick(); #1;
        check("rm_in_valid", 32'(qsn_in_valid), 0);
        check("rm_out_valid", 32'(out_valid), 0);
        check("rm_busy", 32'(busy), 0);
        check("rm_sel_left", 32'(qsn_sel_left), 0);
        check("rm_out_tag", 32'(out_tag), 0);
        check("rm_ready_a", 32'(req_a_ready), 0);
        rst = 1'b0;
        req_a_valid = 0;
        tick(); #1;
        check("rm_no_stale", 32'(out_valid), 0);
        check("rm_busy2", 32'(busy), 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
